// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps up to two requests in
// flight on the instruction-memory interface, buffers returned words in a
// 2-entry queue and hands {PC+4, inst} to decode. A branch redirect takes
// effect when its delay slot is handed over; wrong-path words are cancelled.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [32:0] ID_to_PC_bus,
    input  logic        ID_allow_in,
    output logic        IF_to_ID_valid,
    output logic [63:0] IF_to_ID_bus,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok
);

    logic [31:0]       fetch_pc;
    logic [1:0]        fcnt;
    logic [1:0]        outstanding;
    logic [1:0]        cancel_cnt;
    logic [1:0][31:0]  fq_pc;
    logic [1:0][31:0]  fq_inst;
    logic [1:0][31:0]  pq_pc;

    logic        accept;
    logic        resp;
    logic        handover;
    logic        flush;
    logic        drop;
    logic        push;
    logic [1:0]  outstanding_next;
    logic [31:0] resp_pc;

    // Credit rule: words in flight plus words buffered never exceed the queue
    // depth, so a returning word always finds room. Registered state only.
    assign inst_req  = ({1'b0, outstanding} + {1'b0, fcnt}) < 3'd2;
    assign inst_addr = fetch_pc;
    assign accept    = inst_req & inst_addr_ok;
    assign resp      = inst_data_ok & (outstanding != 2'd0);
    assign resp_pc   = pq_pc[0];

    assign IF_to_ID_valid = (fcnt != 2'd0);
    assign IF_to_ID_bus   = IF_to_ID_valid ? {fq_pc[0] + 32'd4, fq_inst[0]} : 64'd0;

    // The handed-over head is the delay slot; everything behind it is wrong-path.
    assign handover = IF_to_ID_valid & ID_allow_in;
    assign flush    = handover & ID_to_PC_bus[0];
    assign drop     = resp & (flush | (cancel_cnt != 2'd0));
    assign push     = resp & ~drop;

    assign outstanding_next = outstanding + {1'b0, accept} - {1'b0, resp};

    // Fetch PC and in-flight / cancel counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
            cancel_cnt  <= 2'd0;
        end else begin
            outstanding <= outstanding_next;
            if (flush) begin
                fetch_pc   <= {ID_to_PC_bus[32:3], 2'b00};
                cancel_cnt <= outstanding_next;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (resp && cancel_cnt != 2'd0)
                    cancel_cnt <= cancel_cnt - 2'd1;
            end
        end
    end

    // Pending-pc queue: remembers the address of each request in flight so the
    // returning word can be tagged. Its occupancy equals outstanding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pq_pc <= '0;
        end else begin
            case ({resp, accept})
                2'b01: begin
                    if (outstanding == 2'd0) pq_pc[0] <= fetch_pc;
                    else                     pq_pc[1] <= fetch_pc;
                end
                2'b10: pq_pc[0] <= pq_pc[1];
                2'b11: begin
                    if (outstanding == 2'd1) begin
                        pq_pc[0] <= fetch_pc;
                    end else begin
                        pq_pc[0] <= pq_pc[1];
                        pq_pc[1] <= fetch_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Instruction queue toward decode; a flush keeps only the delay slot,
    // which leaves this cycle, so the queue empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt    <= 2'd0;
            fq_pc   <= '0;
            fq_inst <= '0;
        end else if (flush) begin
            fcnt <= 2'd0;
        end else begin
            case ({handover, push})
                2'b01: begin
                    if (fcnt == 2'd0) begin
                        fq_pc[0]   <= resp_pc;
                        fq_inst[0] <= inst_rdata;
                    end else begin
                        fq_pc[1]   <= resp_pc;
                        fq_inst[1] <= inst_rdata;
                    end
                    fcnt <= fcnt + 2'd1;
                end
                2'b10: begin
                    fq_pc[0]   <= fq_pc[1];
                    fq_inst[0] <= fq_inst[1];
                    fcnt       <= fcnt - 2'd1;
                end
                2'b11: begin
                    if (fcnt == 2'd1) begin
                        fq_pc[0]   <= resp_pc;
                        fq_inst[0] <= inst_rdata;
                    end else begin
                        fq_pc[0]   <= fq_pc[1];
                        fq_inst[0] <= fq_inst[1];
                        fq_pc[1]   <= resp_pc;
                        fq_inst[1] <= inst_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model with selectable latency, a
// decode model that redirects on the delay slot at BFC00014, and an
// expected instruction stream 00..14 followed by the target 100, 104, ...
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] DS_PC  = 32'hBFC0_0014;
    localparam logic [31:0] TGT_PC = 32'hBFC0_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [32:0] ID_to_PC_bus;
    logic        ID_allow_in;
    logic        IF_to_ID_valid;
    logic [63:0] IF_to_ID_bus;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .ID_to_PC_bus(ID_to_PC_bus), .ID_allow_in(ID_allow_in),
        .IF_to_ID_valid(IF_to_ID_valid), .IF_to_ID_bus(IF_to_ID_bus),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int n = 0;
    int acc_cnt = 0;
    int flush_cnt = 0;
    int flush_resp = 0;
    bit stall = 0;
    bit hold = 0;
    bit after_flush = 0;
    logic [31:0] first_after = '0;
    logic [31:0] acc_log [16];
    logic [31:0] mem_addr [$];
    int          mem_due  [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pc(input int i);
        if (i < 6) return RST_PC + 32'(4 * i);
        return TGT_PC + 32'(4 * (i - 6));
    endfunction

    // One clock: sample handshakes mid-cycle, then update memory and decode
    // inputs just after the rising edge.
    task automatic tick();
        logic s_acc, s_resp, s_hand, s_flush;
        logic [31:0] s_addr;
        logic [31:0] head;
        @(negedge clk);
        s_acc   = inst_req & inst_addr_ok & ~reset;
        s_resp  = inst_data_ok & ~reset;
        s_hand  = IF_to_ID_valid & ID_allow_in & ~reset;
        s_flush = s_hand & ID_to_PC_bus[0];
        s_addr  = inst_addr;
        if (!reset) begin
            if (s_hand) begin
                check("deliver", IF_to_ID_bus, {exp_pc(n) + 32'd4, ~exp_pc(n)});
                n++;
            end
            if (s_acc) begin
                if (acc_cnt < 16) acc_log[acc_cnt] = s_addr;
                acc_cnt++;
                if (after_flush && !s_flush) begin
                    first_after = s_addr;
                    after_flush = 0;
                end
            end
            if (s_flush) begin
                flush_cnt++;
                if (inst_data_ok) flush_resp++;
                after_flush = 1;
            end
        end
        @(posedge clk);
        #1;
        if (reset) begin
            mem_addr.delete();
            mem_due.delete();
        end else begin
            if (s_resp && mem_addr.size() != 0) begin
                void'(mem_addr.pop_front());
                void'(mem_due.pop_front());
            end
            if (s_acc) begin
                mem_addr.push_back(s_addr);
                mem_due.push_back(cyc + lat);
            end
        end
        cyc++;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        if (!reset && mem_addr.size() != 0) begin
            if (mem_due[0] <= cyc) begin
                inst_data_ok = 1'b1;
                inst_rdata   = ~mem_addr[0];
            end
        end
        head = IF_to_ID_bus[63:32] - 32'd4;
        ID_allow_in  = ~stall & ~(hold & IF_to_ID_valid & (head == DS_PC) & ~inst_data_ok);
        ID_to_PC_bus = (IF_to_ID_valid && head == DS_PC) ? {TGT_PC, 1'b1} : 33'd0;
    endtask

    task automatic run_until(input int target, input int budget);
        int b = budget;
        while (n < target && b > 0) begin
            tick();
            b--;
        end
        if (n < target) check("timeout", 64'(n), 64'(target));
    endtask

    task automatic clear_counts();
        n = 0; acc_cnt = 0; flush_cnt = 0; flush_resp = 0;
        after_flush = 0; first_after = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        inst_data_ok = 1'b0;
        stall = 0;
        hold = 0;
        tick();
        tick();
        clear_counts();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ID_to_PC_bus = '0;
        ID_allow_in = 1'b1;
        inst_addr_ok = 1'b1;
        inst_rdata = '0;
        inst_data_ok = 1'b0;
        #3;
        check("rst_valid", IF_to_ID_valid, 1'b0);
        check("rst_bus", IF_to_ID_bus, 64'd0);
        check("rst_req", inst_req, 1'b1);
        check("rst_addr", inst_addr, RST_PC);

        // 1-cycle memory, decode never stalls, branch at 10 -> 100
        lat = 1;
        do_reset();
        tick();
        check("lat_c1_valid", IF_to_ID_valid, 1'b0);
        tick();
        check("lat_c2_valid", IF_to_ID_valid, 1'b1);
        check("lat_c2_bus", IF_to_ID_bus, {32'hBFC0_0004, ~32'hBFC0_0000});
        run_until(12, 200);
        check("req0", acc_log[0], 32'hBFC0_0000);
        check("req1", acc_log[1], 32'hBFC0_0004);
        check("req2", acc_log[2], 32'hBFC0_0008);
        check("l1_flushes", 64'(flush_cnt), 64'd1);
        check("l1_target_req", first_after, TGT_PC);

        // decode stall for several cycles: queue fills, requests stop
        do_reset();
        run_until(2, 50);
        stall = 1;
        ID_allow_in = 1'b0;
        repeat (5) tick();
        check("stall_valid", IF_to_ID_valid, 1'b1);
        check("stall_req", inst_req, 1'b0);
        check("stall_head", IF_to_ID_bus, {32'hBFC0_000C, ~32'hBFC0_0008});
        tick();
        check("stall_head_hold", IF_to_ID_bus, {32'hBFC0_000C, ~32'hBFC0_0008});
        check("stall_req_hold", inst_req, 1'b0);
        stall = 0;
        ID_allow_in = 1'b1;
        run_until(12, 200);

        // 3-cycle memory with the branch
        lat = 3;
        do_reset();
        run_until(12, 300);
        check("l3_flushes", 64'(flush_cnt), 64'd1);
        check("l3_target_req", first_after, TGT_PC);

        // decode holds the delay slot until a word returns: flush-cycle response dropped
        do_reset();
        hold = 1;
        run_until(12, 300);
        check("hold_flushes", 64'(flush_cnt), 64'd1);
        check("hold_flush_resp", 64'(flush_resp), 64'd1);
        check("hold_target_req", first_after, TGT_PC);

        // reset while two requests are in flight
        do_reset();
        begin
            int b = 50;
            while (acc_cnt < 4 && b > 0) begin
                tick();
                b--;
            end
            if (acc_cnt < 4) check("timeout_acc", 64'(acc_cnt), 64'd4);
        end
        check("full_req", inst_req, 1'b0);
        check("full_addr", inst_addr, 32'hBFC0_0010);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", IF_to_ID_valid, 1'b0);
        check("mid_rst_bus", IF_to_ID_bus, 64'd0);
        check("mid_rst_req", inst_req, 1'b1);
        check("mid_rst_addr", inst_addr, RST_PC);
        tick();
        tick();
        clear_counts();
        reset = 1'b0;
        run_until(8, 200);
        check("resume_req", acc_log[0], RST_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d exp 0", 1);
        $fatal(1, "timeout");
    end

endmodule
